alu_accum_4bit: RTL

Sequential 4-bit accumulator ALU. It sits directly downstream of the 4-bit 2:1 operand mux, whose output drives `operand`. It accepts one opcode/operand pair per handshake and applies it to an internal accumulator. Single-cycle ops cover load, add, sub, and, or, xor and clear; an unsigned 4x4 multiply runs as a 4-cycle shift-add sequence. Results and flags stay visible until the next operation.

---
 rtl/alu_accum_4bit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_accum_4bit.sv
// 4-bit accumulator ALU: single-cycle logic/arith ops on an internal accumulator,
// plus an unsigned 4x4 multiply run as a four-step shift-add sequence.
module alu_accum_4bit (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] opcode,
  input  logic [3:0] operand,
  output logic [3:0] acc,
  output logic [3:0] acc_hi,
  output logic       carry,
  output logic       overflow,
  output logic       zero,
  output logic       done
);

  localparam int DATA_W = 4;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t state, state_next;

  logic                  accept;
  logic                  mul_last;
  logic [1:0]            count;
  logic [2*DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]     mplier;
  logic [2*DATA_W-1:0]   prod;
  logic [2*DATA_W-1:0]   addend;
  logic [2*DATA_W-1:0]   prod_next;
  logic [DATA_W-1:0]     alu_res;
  logic                  alu_carry;
  logic                  alu_ovf;

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] s;
    s = a + b;
    return s[DATA_W] ^ s[DATA_W-1];
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] s;
    s = a - b;
    return s[DATA_W] ^ s[DATA_W-1];
  endfunction

  assign accept   = in_valid && in_ready;
  assign mul_last = (state == MUL) && (count == 2'd3);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept && opcode == OP_MUL) state_next = MUL;
      MUL:     if (count == 2'd3) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  // Single-cycle result; borrow of SUB falls out as bit 4 of the unsigned difference.
  always_comb begin
    alu_res   = acc;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    unique case (opcode)
      OP_LOAD: alu_res = operand;
      OP_ADD: begin
        {alu_carry, alu_res} = {1'b0, acc} + {1'b0, operand};
        alu_ovf = add_ovf($signed(acc), $signed(operand));
      end
      OP_SUB: begin
        {alu_carry, alu_res} = {1'b0, acc} - {1'b0, operand};
        alu_ovf = sub_ovf($signed(acc), $signed(operand));
      end
      OP_AND:  alu_res = acc & operand;
      OP_OR:   alu_res = acc | operand;
      OP_XOR:  alu_res = acc ^ operand;
      OP_MUL:  alu_res = acc;
      OP_CLR:  alu_res = '0;
      default: alu_res = acc;
    endcase
  end

  always_comb begin
    addend    = mplier[count] ? (mcand << count) : '0;
    prod_next = prod + addend;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      acc_hi   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      done     <= 1'b0;
      count    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (opcode == OP_MUL) begin
          mcand  <= {{DATA_W{1'b0}}, acc};
          mplier <= operand;
          prod   <= '0;
          count  <= '0;
        end else begin
          acc      <= alu_res;
          carry    <= alu_carry;
          overflow <= alu_ovf;
          zero     <= (alu_res == '0);
          done     <= 1'b1;
          if (opcode == OP_CLR) acc_hi <= '0;
        end
      end else if (state == MUL) begin
        prod  <= prod_next;
        count <= count + 2'd1;
        if (mul_last) begin
          acc      <= prod_next[DATA_W-1:0];
          acc_hi   <= prod_next[2*DATA_W-1:DATA_W];
          carry    <= (prod_next[2*DATA_W-1:DATA_W] != '0);
          overflow <= 1'b0;
          zero     <= (prod_next == '0);
          done     <= 1'b1;
        end
      end
    end
  end

endmodule
